fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls words from a show-ahead-less FIFO (read data appears the cycle after
//   the read strobe) and serialises each one as an asynchronous UART frame:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, then
//   STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT rd_clk cycles.
//
// Ports
//   rd_clk        in   sole clock, FIFO read domain, rising edge
//   rst           in   asynchronous active-high reset
//   tx_en         in   allows a new word to be fetched (never cuts a frame)
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_data  in   FIFO read word, valid the cycle after fifo_rd_en
//   fifo_rd_en    out  registered one-cycle read strobe
//   tx            out  registered serial line, idle high
//   busy          out  high from fetch through the last stop bit
//   frame_done    out  pulse in the final cycle of the last stop bit
//   state_dbg     out  current FSM state, for observation only
//
// FIFO read protocol: the block raises fifo_rd_en for exactly one cycle (FETCH)
// only after seeing fifo_empty low in IDLE; the FIFO registers the word on the
// edge that samples the strobe, so the word is stable during LOAD and is
// captured at the end of LOAD. There is no back-pressure from the FIFO side.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            state_dbg
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] PARITY = 3'd5;
    localparam logic [2:0] STOP   = 3'd6;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  armed;

    logic                  bit_end;
    logic                  last_stop;
    logic                  in_bit;
    logic [DATA_WIDTH-1:0] shreg_next;

    assign in_bit     = (state == START) || (state == DATA) ||
                        (state == PARITY) || (state == STOP);
    assign bit_end    = (clk_cnt == CNT_LAST);
    assign last_stop  = (STOP_BITS == 1) || stop_idx;
    assign shreg_next = shreg >> 1;

    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && last_stop && bit_end;
    assign state_dbg  = state;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            // 'armed' holds off the first fetch for one edge after reset
            // release so the FIFO never sees a strobe on the first edge.
            armed      <= 1'b1;
            fifo_rd_en <= 1'b0;

            // One bit-period timer shared by every serial bit; it wraps on
            // each bit boundary.
            if (in_bit) begin
                clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (armed && tx_en && !fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg   <= fifo_rd_data;
                    par_bit <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
                    clk_cnt <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg_next;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_idx <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shreg_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx <= 1'b1;
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
